fetch_skid_stage: RTL and testbench
===================================

FETCH_SKID_STAGE -- requirements
Module: fetch_skid_stage

Interface
REQ-001 Parameter LANES, default 2, instructions per fetch bundle (1..8).
REQ-002 Parameter PC_W, default 32, PC width per lane.
REQ-003 Parameter BR_W, default 34, branch-type/predicted-PC field width per lane.
REQ-004 Parameter EC_W, default 8, exception code width; bit EC_W-1 = exception-present flag.
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 rstn  input  1  reset, synchronous, active-low.
REQ-007 in_valid  input  1  upstream bundle valid.
REQ-008 in_ready  output  1  stage can accept a bundle; registered, not a function of out_ready.
REQ-009 in_lane_mask  input  LANES  per-lane valid within the bundle.
REQ-010 in_pc  input  LANES*PC_W  lane i at [i*PC_W +: PC_W].
REQ-011 in_br  input  LANES*BR_W  lane i at [i*BR_W +: BR_W].
REQ-012 in_ecode  input  EC_W  bundle exception code, shared by all lanes.
REQ-013 flush  input  1  kill all held and incoming bundles.
REQ-014 out_ready  input  1  downstream accepts the presented bundle.
REQ-015 out_valid  output  1  bundle presented.
REQ-016 out_lane_valid  output  LANES  per-lane valid of the presented bundle.
REQ-017 out_pc, out_br  output  LANES*PC_W, LANES*BR_W  presented bundle payload.
REQ-018 out_ecode  output  LANES*EC_W  per-lane copy of the bundle ecode.
REQ-019 out_exc  output  1  presented bundle carries an exception.
REQ-020 occupancy  output  2  bundles held (0..2).
REQ-021 flush_drops  output  16  saturating count of bundles discarded by flush.

Function
REQ-022 Storage: two entries, MAIN (oldest, drives outputs) and SKID, each with valid bit, lane mask, pc, br, ecode.
REQ-023 Accept = in_valid & in_ready & ~flush; Pop = out_valid & out_ready.
REQ-024 in_ready = ~SKID.valid, updated at the clock edge only.
REQ-025 MAIN empty, Accept: bundle -> MAIN.
REQ-026 MAIN full, Pop, SKID full: SKID -> MAIN, SKID cleared (no Accept possible).
REQ-027 MAIN full, Pop, SKID empty: Accept bundle -> MAIN, else MAIN cleared.
REQ-028 MAIN full, no Pop, Accept: bundle -> SKID (in_ready falls next cycle).
REQ-029 Order is strict FIFO; zero-cycle bypass is not provided; latency input->output is 1 cycle when empty.
REQ-030 out_valid = MAIN.valid & ~flush (combinational kill, same cycle).
REQ-031 out_lane_valid = MAIN.mask & {LANES{out_valid}}, with lanes 1..LANES-1 forced 0 when MAIN.ecode[EC_W-1]=1 (exception lane 0 kills younger lanes).
REQ-032 out_exc = MAIN.valid & MAIN.ecode[EC_W-1] (not masked by flush).
REQ-033 Payload registers update only when loaded; otherwise hold value.
REQ-034 Flush (priority over all): next cycle MAIN.valid=SKID.valid=0, in_ready=1; concurrent in_valid bundle discarded.
REQ-035 flush_drops increments by (MAIN.valid+SKID.valid+in_valid&in_ready) on a flush cycle, saturates at 16'hFFFF.
REQ-036 in_valid with in_lane_mask=0 is still accepted as a bundle.
REQ-037 occupancy = MAIN.valid + SKID.valid.

Reset
REQ-038 rstn=0 at edge: MAIN.valid=SKID.valid=0, in_ready=1, occupancy=0, flush_drops=0; payload undefined, out_valid=0, out_lane_valid=0, out_exc=0.
REQ-039 Reset overrides flush and handshake in the same cycle.

Verification
REQ-040 Empty, in_valid=1, mask=2'b11, pc={0x1c000004,0x1c000000}, out_ready=1 -> next cycle out_valid=1, out_lane_valid=2'b11, same pc; occupancy=1.
REQ-041 out_ready=0, three bundles offered back-to-back -> first two held, in_ready=0 after second, third held upstream; out_ready=1 then delivers in order A,B,C.
REQ-042 Two held bundles, flush=1 with in_valid=0 -> same cycle out_valid=0; next cycle occupancy=0, in_ready=1, flush_drops=2.
REQ-043 ecode=0x88, mask=2'b11 -> out_exc=1, out_lane_valid=2'b01, out_ecode both lanes 0x88.
REQ-044 flush_drops preset near 0xFFFF by repeated flushes -> stays 0xFFFF.
REQ-045 rstn=0 while occupancy=2 -> next cycle occupancy=0, out_valid=0, in_ready=1.

Source files
------------

// File: rtl/fetch_skid_stage_if.sv
// Fetch-bundle channel between the fetch stage and its upstream/downstream neighbours.
// The slave modport is the stage itself; the master modport is whoever drives it.
interface fetch_skid_stage_if #(
  parameter int LANES = 2,
  parameter int PC_W  = 32,
  parameter int BR_W  = 34,
  parameter int EC_W  = 8
);
  logic                    in_valid;
  logic                    in_ready;
  logic [LANES-1:0]        in_lane_mask;
  logic [LANES*PC_W-1:0]   in_pc;
  logic [LANES*BR_W-1:0]   in_br;
  logic [EC_W-1:0]         in_ecode;
  logic                    flush;
  logic                    out_ready;
  logic                    out_valid;
  logic [LANES-1:0]        out_lane_valid;
  logic [LANES*PC_W-1:0]   out_pc;
  logic [LANES*BR_W-1:0]   out_br;
  logic [LANES*EC_W-1:0]   out_ecode;
  logic                    out_exc;
  logic [1:0]              occupancy;
  logic [15:0]             flush_drops;

  modport slave (
    input  in_valid, in_lane_mask, in_pc, in_br, in_ecode, flush, out_ready,
    output in_ready, out_valid, out_lane_valid, out_pc, out_br, out_ecode,
           out_exc, occupancy, flush_drops
  );

  modport master (
    output in_valid, in_lane_mask, in_pc, in_br, in_ecode, flush, out_ready,
    input  in_ready, out_valid, out_lane_valid, out_pc, out_br, out_ecode,
           out_exc, occupancy, flush_drops
  );
endinterface

// File: rtl/fetch_skid_stage.sv
// Two-entry fetch skid buffer: MAIN drives the outputs, SKID catches the bundle that
// arrives while MAIN is stalled, so in_ready can be a plain register.
module fetch_skid_stage #(
  parameter int LANES = 2,
  parameter int PC_W  = 32,
  parameter int BR_W  = 34,
  parameter int EC_W  = 8
) (
  input  logic clk,
  input  logic rstn,
  fetch_skid_stage_if.slave bus
);

  logic                  main_v_q, main_v_d, skid_v_q, skid_v_d;
  logic [LANES-1:0]      main_mask_q, main_mask_d, skid_mask_q, skid_mask_d;
  logic [LANES*PC_W-1:0] main_pc_q, main_pc_d, skid_pc_q, skid_pc_d;
  logic [LANES*BR_W-1:0] main_br_q, main_br_d, skid_br_q, skid_br_d;
  logic [EC_W-1:0]       main_ec_q, main_ec_d, skid_ec_q, skid_ec_d;
  logic [15:0]           drops_q, drops_d;
  logic [16:0]           drops_sum;
  logic [1:0]            drop_inc;
  logic                  accept, pop, out_valid;
  logic [LANES-1:0]      lane_valid;

  always_comb begin
    accept      = bus.in_valid & ~skid_v_q & ~bus.flush;
    out_valid   = main_v_q & ~bus.flush;
    pop         = out_valid & bus.out_ready;
    main_v_d    = main_v_q;
    main_mask_d = main_mask_q;
    main_pc_d   = main_pc_q;
    main_br_d   = main_br_q;
    main_ec_d   = main_ec_q;
    skid_v_d    = skid_v_q;
    skid_mask_d = skid_mask_q;
    skid_pc_d   = skid_pc_q;
    skid_br_d   = skid_br_q;
    skid_ec_d   = skid_ec_q;

    if (!main_v_q) begin
      if (accept) begin
        main_v_d    = 1'b1;
        main_mask_d = bus.in_lane_mask;
        main_pc_d   = bus.in_pc;
        main_br_d   = bus.in_br;
        main_ec_d   = bus.in_ecode;
      end
    end else if (pop) begin
      // SKID always holds the older bundle, so it must refill MAIN before any new input
      if (skid_v_q) begin
        main_mask_d = skid_mask_q;
        main_pc_d   = skid_pc_q;
        main_br_d   = skid_br_q;
        main_ec_d   = skid_ec_q;
        skid_v_d    = 1'b0;
      end else if (accept) begin
        main_mask_d = bus.in_lane_mask;
        main_pc_d   = bus.in_pc;
        main_br_d   = bus.in_br;
        main_ec_d   = bus.in_ecode;
      end else begin
        main_v_d    = 1'b0;
      end
    end else if (accept) begin
      skid_v_d    = 1'b1;
      skid_mask_d = bus.in_lane_mask;
      skid_pc_d   = bus.in_pc;
      skid_br_d   = bus.in_br;
      skid_ec_d   = bus.in_ecode;
    end

    if (bus.flush) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
    end

    drop_inc  = {1'b0, main_v_q} + {1'b0, skid_v_q} + {1'b0, bus.in_valid & ~skid_v_q};
    drops_sum = {1'b0, drops_q} + {15'b0, drop_inc};
    drops_d   = drops_q;
    if (bus.flush) drops_d = drops_sum[16] ? 16'hFFFF : drops_sum[15:0];

    // an excepting bundle keeps only lane 0 alive
    for (int i = 0; i < LANES; i++)
      lane_valid[i] = main_mask_q[i] & out_valid & ((i == 0) | ~main_ec_q[EC_W-1]);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
      drops_q  <= 16'h0000;
    end else begin
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
      drops_q  <= drops_d;
    end
  end

  always_ff @(posedge clk) begin
    main_mask_q <= main_mask_d;
    main_pc_q   <= main_pc_d;
    main_br_q   <= main_br_d;
    main_ec_q   <= main_ec_d;
    skid_mask_q <= skid_mask_d;
    skid_pc_q   <= skid_pc_d;
    skid_br_q   <= skid_br_d;
    skid_ec_q   <= skid_ec_d;
  end

  assign bus.in_ready       = ~skid_v_q;
  assign bus.out_valid      = out_valid;
  assign bus.out_lane_valid = lane_valid;
  assign bus.out_pc         = main_pc_q;
  assign bus.out_br         = main_br_q;
  assign bus.out_ecode      = {LANES{main_ec_q}};
  assign bus.out_exc        = main_v_q & main_ec_q[EC_W-1];
  assign bus.occupancy      = {1'b0, main_v_q} + {1'b0, skid_v_q};
  assign bus.flush_drops    = drops_q;

endmodule

// File: tb/tb_fetch_skid_stage.sv
// Directed bench for fetch_skid_stage: a vector table for the handshake/ordering cases,
// then hand-written sequences for same-cycle flush kill and flush_drops saturation.
module tb_fetch_skid_stage;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  fetch_skid_stage_if #(.LANES(2), .PC_W(32), .BR_W(34), .EC_W(8)) bus ();

  fetch_skid_stage #(.LANES(2), .PC_W(32), .BR_W(34), .EC_W(8)) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  typedef struct {
    logic        rst_b;
    logic        iv;
    logic [1:0]  mask;
    logic [63:0] pc;
    logic [7:0]  ec;
    logic        fl;
    logic        ordy;
    logic        e_ov;
    logic [1:0]  e_lv;
    logic [63:0] e_pc;
    logic        e_exc;
    logic        e_irdy;
    logic [1:0]  e_occ;
    logic [15:0] e_drops;
  } vec_t;

  localparam logic [63:0] PC0 = {32'h1c000004, 32'h1c000000};
  localparam logic [63:0] PCA = {32'h1c000014, 32'h1c000010};
  localparam logic [63:0] PCB = {32'h1c000024, 32'h1c000020};
  localparam logic [63:0] PCC = {32'h1c000034, 32'h1c000030};
  localparam logic [63:0] PCD = {32'h1c000044, 32'h1c000040};
  localparam logic [63:0] PCE = {32'h1c000054, 32'h1c000050};
  localparam logic [63:0] PCF = {32'h1c000064, 32'h1c000060};
  localparam logic [63:0] PCG = {32'h1c000074, 32'h1c000070};
  localparam logic [63:0] PCH = {32'h1c000084, 32'h1c000080};
  localparam logic [63:0] PCI = {32'h1c000094, 32'h1c000090};
  localparam logic [63:0] PCJ = {32'h1c0000a4, 32'h1c0000a0};

  vec_t vecs[19];
  int   applied = 0;
  int   miscompares = 0;

  function automatic vec_t mk(logic r, logic iv, logic [1:0] m, logic [63:0] pc,
                              logic [7:0] ec, logic fl, logic ordy, logic ov,
                              logic [1:0] lv, logic [63:0] epc, logic exc,
                              logic irdy, logic [1:0] occ, logic [15:0] dr);
    vec_t v;
    v.rst_b = r; v.iv = iv; v.mask = m; v.pc = pc; v.ec = ec; v.fl = fl; v.ordy = ordy;
    v.e_ov = ov; v.e_lv = lv; v.e_pc = epc; v.e_exc = exc; v.e_irdy = irdy;
    v.e_occ = occ; v.e_drops = dr;
    return v;
  endfunction

  function automatic logic [67:0] br_of(logic [63:0] pc);
    return {2'b10, pc[63:32], 2'b01, pc[31:0]};
  endfunction

  task automatic chk(input string nm, input int idx, input logic [127:0] act,
                     input logic [127:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s step %0d: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  // one clock with the given inputs; handshake/flush/reset are dropped 1ns after the edge
  task automatic step(input logic r, input logic iv, input logic [1:0] m,
                      input logic [63:0] pc, input logic [7:0] ec, input logic fl,
                      input logic ordy);
    @(negedge clk);
    rstn = r;
    bus.in_valid = iv;
    bus.in_lane_mask = m;
    bus.in_pc = pc;
    bus.in_br = br_of(pc);
    bus.in_ecode = ec;
    bus.flush = fl;
    bus.out_ready = ordy;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    bus.in_valid = 1'b0;
    bus.flush = 1'b0;
    #1;
  endtask

  task automatic check_state(input int idx, input logic ov, input logic [1:0] lv,
                             input logic [63:0] pc, input logic exc, input logic irdy,
                             input logic [1:0] occ, input logic [15:0] dr);
    applied++;
    chk("out_valid", idx, 128'(bus.out_valid), 128'(ov));
    chk("out_lane_valid", idx, 128'(bus.out_lane_valid), 128'(lv));
    chk("in_ready", idx, 128'(bus.in_ready), 128'(irdy));
    chk("occupancy", idx, 128'(bus.occupancy), 128'(occ));
    chk("flush_drops", idx, 128'(bus.flush_drops), 128'(dr));
    if (ov) begin
      chk("out_pc", idx, 128'(bus.out_pc), 128'(pc));
      chk("out_br", idx, 128'(bus.out_br), 128'(br_of(pc)));
      chk("out_exc", idx, 128'(bus.out_exc), 128'(exc));
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_lane_mask = 2'b00;
    bus.in_pc = '0;
    bus.in_br = '0;
    bus.in_ecode = '0;
    bus.flush = 1'b0;
    bus.out_ready = 1'b0;

    //           rst iv mask  pc   ec    fl ordy | ov lv     pc   exc irdy occ dr
    vecs[0]  = mk(0, 0, 2'b00, 0,   8'h00, 0, 1,   0, 2'b00, 0,   0,  1,  0, 0);
    vecs[1]  = mk(1, 1, 2'b11, PC0, 8'h00, 0, 1,   1, 2'b11, PC0, 0,  1,  1, 0);
    vecs[2]  = mk(1, 0, 2'b00, 0,   8'h00, 0, 1,   0, 2'b00, 0,   0,  1,  0, 0);
    vecs[3]  = mk(1, 1, 2'b01, PCA, 8'h00, 0, 0,   1, 2'b01, PCA, 0,  1,  1, 0);
    vecs[4]  = mk(1, 1, 2'b10, PCB, 8'h00, 0, 0,   1, 2'b01, PCA, 0,  0,  2, 0);
    vecs[5]  = mk(1, 1, 2'b11, PCC, 8'h00, 0, 0,   1, 2'b01, PCA, 0,  0,  2, 0);
    vecs[6]  = mk(1, 1, 2'b11, PCC, 8'h00, 0, 1,   1, 2'b10, PCB, 0,  1,  1, 0);
    vecs[7]  = mk(1, 1, 2'b11, PCC, 8'h00, 0, 1,   1, 2'b11, PCC, 0,  1,  1, 0);
    vecs[8]  = mk(1, 0, 2'b00, 0,   8'h00, 0, 1,   0, 2'b00, 0,   0,  1,  0, 0);
    vecs[9]  = mk(1, 1, 2'b11, PCD, 8'h88, 0, 0,   1, 2'b01, PCD, 1,  1,  1, 0);
    vecs[10] = mk(1, 1, 2'b00, PCE, 8'h00, 0, 0,   1, 2'b01, PCD, 1,  0,  2, 0);
    vecs[11] = mk(1, 0, 2'b00, 0,   8'h00, 0, 1,   1, 2'b00, PCE, 0,  1,  1, 0);
    vecs[12] = mk(1, 1, 2'b11, PCF, 8'h00, 0, 0,   1, 2'b00, PCE, 0,  0,  2, 0);
    vecs[13] = mk(1, 0, 2'b00, 0,   8'h00, 1, 1,   0, 2'b00, 0,   0,  1,  0, 2);
    vecs[14] = mk(1, 1, 2'b11, PCG, 8'h00, 1, 1,   0, 2'b00, 0,   0,  1,  0, 3);
    vecs[15] = mk(1, 1, 2'b11, PCH, 8'h00, 0, 0,   1, 2'b11, PCH, 0,  1,  1, 3);
    vecs[16] = mk(1, 1, 2'b11, PCI, 8'h00, 0, 0,   1, 2'b11, PCH, 0,  0,  2, 3);
    vecs[17] = mk(0, 1, 2'b11, PCJ, 8'h00, 1, 1,   0, 2'b00, 0,   0,  1,  0, 0);
    vecs[18] = mk(1, 1, 2'b11, PCJ, 8'h00, 0, 1,   1, 2'b11, PCJ, 0,  1,  1, 0);

    foreach (vecs[i]) begin
      step(vecs[i].rst_b, vecs[i].iv, vecs[i].mask, vecs[i].pc, vecs[i].ec,
           vecs[i].fl, vecs[i].ordy);
      check_state(i, vecs[i].e_ov, vecs[i].e_lv, vecs[i].e_pc, vecs[i].e_exc,
                  vecs[i].e_irdy, vecs[i].e_occ, vecs[i].e_drops);
      if (i == 9) begin
        applied++;
        chk("out_ecode", i, 128'(bus.out_ecode), 128'(16'h8888));
      end
    end

    // same-cycle flush kill with two bundles held, MAIN excepting
    step(1, 0, 2'b00, 0, 8'h00, 0, 1);
    step(1, 1, 2'b11, PCA, 8'h88, 0, 0);
    step(1, 1, 2'b11, PCB, 8'h00, 0, 0);
    check_state(100, 1, 2'b01, PCA, 1, 0, 2, 0);
    @(negedge clk);
    bus.flush = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    applied++;
    chk("flush_kill_out_valid", 101, 128'(bus.out_valid), 128'(0));
    chk("flush_kill_lane_valid", 101, 128'(bus.out_lane_valid), 128'(0));
    chk("flush_kill_out_exc", 101, 128'(bus.out_exc), 128'(1));
    chk("flush_kill_out_ecode", 101, 128'(bus.out_ecode), 128'(16'h8888));
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    #1;
    check_state(102, 0, 2'b00, 0, 0, 1, 0, 2);

    // saturation: 65533 single drops, then two double drops
    step(0, 0, 2'b00, 0, 8'h00, 0, 1);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.flush = 1'b1;
    repeat (65533) @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.flush = 1'b0;
    #1;
    check_state(200, 0, 2'b00, 0, 0, 1, 0, 16'hFFFD);
    step(1, 1, 2'b01, PCA, 8'h00, 0, 0);
    step(1, 1, 2'b01, PCB, 8'h00, 0, 0);
    step(1, 0, 2'b00, 0, 8'h00, 1, 0);
    check_state(201, 0, 2'b00, 0, 0, 1, 0, 16'hFFFF);
    step(1, 1, 2'b01, PCC, 8'h00, 0, 0);
    step(1, 1, 2'b01, PCD, 8'h00, 0, 0);
    check_state(202, 1, 2'b01, PCC, 0, 0, 2, 16'hFFFF);
    step(1, 0, 2'b00, 0, 8'h00, 1, 0);
    check_state(203, 0, 2'b00, 0, 0, 1, 0, 16'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
